// File: rtl/counter_sequencer.sv
// Sequencer FSM for an external up/down counter: load, prescaled enables, stop at limit, optional auto-reload.
// Latency: start accepted -> load strobe next cycle; outputs decode registered state, o_cnt_en is combinational on i_count/i_pause/i_stop.
// Backpressure: i_pause freezes counting with prescaler phase held; i_stop aborts to IDLE. Macro COUNTER_SEQUENCER_LAP_COUNT_EN adds o_laps.
module counter_sequencer #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_pause,
    input  logic                  i_repeat,
    input  logic                  i_dir,
    input  logic [WIDTH-1:0]      i_start_val,
    input  logic [WIDTH-1:0]      i_limit,
    input  logic [PRESCALE_W-1:0] i_prescale,
    input  logic [WIDTH-1:0]      i_count,
    output logic                  o_cnt_load,
    output logic [WIDTH-1:0]      o_load_val,
    output logic                  o_cnt_en,
    output logic                  o_cnt_dir,
    output logic                  o_busy,
`ifdef COUNTER_SEQUENCER_LAP_COUNT_EN
    output logic [7:0]            o_laps,
`endif
    output logic                  o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t                  state;
    logic                    cfg_repeat;
    logic                    cfg_dir;
    logic [WIDTH-1:0]        cfg_start_val;
    logic [WIDTH-1:0]        cfg_limit;
    logic [PRESCALE_W-1:0]   cfg_prescale;
    logic [PRESCALE_W-1:0]   prescaler;
`ifdef COUNTER_SEQUENCER_LAP_COUNT_EN
    logic [7:0]              laps;
`endif

    logic at_limit;
    logic tick;

    assign at_limit = (i_count == cfg_limit);
    assign tick     = (prescaler == cfg_prescale);

    // Enable is suppressed on the compare cycle so the counter never overshoots the limit.
    assign o_cnt_en   = (state == S_RUN) && !i_stop && !at_limit && !i_pause && tick;
    assign o_cnt_load = (state == S_LOAD);
    assign o_load_val = cfg_start_val;
    assign o_cnt_dir  = cfg_dir;
    assign o_busy     = (state != S_IDLE);
    assign o_done     = (state == S_DONE);
`ifdef COUNTER_SEQUENCER_LAP_COUNT_EN
    assign o_laps     = laps;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= S_IDLE;
            cfg_repeat    <= 1'b0;
            cfg_dir       <= 1'b0;
            cfg_start_val <= '0;
            cfg_limit     <= '0;
            cfg_prescale  <= '0;
            prescaler     <= '0;
`ifdef COUNTER_SEQUENCER_LAP_COUNT_EN
            laps          <= 8'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start && !i_stop) begin
                        cfg_repeat    <= i_repeat;
                        cfg_dir       <= i_dir;
                        cfg_start_val <= i_start_val;
                        cfg_limit     <= i_limit;
                        cfg_prescale  <= i_prescale;
                        prescaler     <= '0;
`ifdef COUNTER_SEQUENCER_LAP_COUNT_EN
                        laps          <= 8'd0;
`endif
                        state         <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state <= i_stop ? S_IDLE : S_RUN;
                end
                S_RUN: begin
                    if (i_stop) begin
                        state <= S_IDLE;
                    end else if (at_limit) begin
                        state <= S_DONE;
`ifdef COUNTER_SEQUENCER_LAP_COUNT_EN
                        if (laps != 8'hFF)
                            laps <= laps + 8'd1;
`endif
                    end else if (i_pause) begin
                        state <= S_HOLD;
                    end else if (tick) begin
                        prescaler <= '0;
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (i_stop)
                        state <= S_IDLE;
                    else if (!i_pause)
                        state <= S_RUN;
                end
                S_DONE: begin
                    // Auto-reload restarts the prescaler phase along with the counter value.
                    if (i_stop) begin
                        state <= S_IDLE;
                    end else if (cfg_repeat) begin
                        prescaler <= '0;
                        state     <= S_LOAD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
